flag_pipe: RTL

Parametrised, two-stage pipelined condition-flag unit for the ARM datapath. It detects zero and negative on an ALU result of configurable width using a grouped NOR reduction. It passes carry/overflow alongside and commits NZCV into an architectural flag register when the instruction sets flags. It sits between the ALU output and the branch/condition logic, and supports stall and flush from the pipeline controller.

---
 rtl/flag_pkg.sv | 22 ++
 rtl/group_zero.sv | 11 +
 rtl/flag_pipe.sv | 93 +++++++++
 3 files changed

// File: rtl/flag_pkg.sv
// Shared types and configuration checks for the pipelined NZCV flag unit.
package flag_pkg;

    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    // GROUP must be a power of two, at least 4 and at most WIDTH; WIDTH must split evenly into groups.
    function automatic bit legal_cfg(input int width, input int group);
        return (group >= 4) && (group <= width) &&
               ((group & (group - 1)) == 0) && ((width % group) == 0);
    endfunction

endpackage

// File: rtl/group_zero.sv
// Combinational NOR reduction over one GROUP-bit slice of the ALU result.
module group_zero #(
    parameter int GROUP = 16
) (
    input  logic [GROUP-1:0] slice,
    output logic             zero
);

    assign zero = ~|slice;

endmodule

// File: rtl/flag_pipe.sv
// Two-stage condition-flag pipeline: grouped zero detect in S1, final AND and NZCV commit in S2.
module flag_pipe
    import flag_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int GROUP = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] result,
    input  logic             carry_in,
    input  logic             ovf_in,
    input  logic             set_flags,
    input  logic             stall,
    input  logic             flush,
    output logic             out_valid,
    output logic             res_zero,
    output logic [3:0]       flags
);

    localparam int N_GRP = WIDTH / GROUP;

    if (!legal_cfg(WIDTH, GROUP)) begin : g_bad_cfg
        $error("flag_pipe: WIDTH must be a multiple of GROUP, GROUP a power of 2 in 4..WIDTH");
    end

    logic [N_GRP-1:0] grp_zero;

    for (genvar gi = 0; gi < N_GRP; gi++) begin : g_grp
        group_zero #(.GROUP(GROUP)) u_group_zero (
            .slice (result[gi*GROUP +: GROUP]),
            .zero  (grp_zero[gi])
        );
    end

    logic             s1_valid;
    logic             s1_set_flags;
    logic             s1_neg;
    logic             s1_c;
    logic             s1_v;
    logic [N_GRP-1:0] s1_grp_zero;

    logic             s2_valid;
    logic             s2_zero;
    nzcv_t            flags_q;

    logic             s1_zero;
    logic             commit;

    assign s1_zero = &s1_grp_zero;
    assign commit  = s1_valid & s1_set_flags;

    // NOTE: every pipeline register, datapath included, sits on the async reset so that
    // a mid-operation reset leaves no stale state and flags reads zero without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid     <= 1'b0;
            s1_set_flags <= 1'b0;
            s1_neg       <= 1'b0;
            s1_c         <= 1'b0;
            s1_v         <= 1'b0;
            s1_grp_zero  <= '0;
            s2_valid     <= 1'b0;
            s2_zero      <= 1'b0;
            flags_q      <= '0;
        end else if (flush) begin
            // Flush wins over stall: kill both entries, drop the input, leave flags alone.
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (!stall) begin
            s1_valid     <= in_valid;
            s1_set_flags <= set_flags;
            s1_neg       <= result[WIDTH-1];
            s1_c         <= carry_in;
            s1_v         <= ovf_in;
            s1_grp_zero  <= grp_zero;
            s2_valid     <= s1_valid;
            s2_zero      <= s1_zero;
            if (commit) begin
                flags_q <= '{n: s1_neg, z: s1_zero, c: s1_c, v: s1_v};
            end
        end
    end

    assign out_valid    = s2_valid;
    assign res_zero     = s2_zero;
    assign flags[N_BIT] = flags_q.n;
    assign flags[Z_BIT] = flags_q.z;
    assign flags[C_BIT] = flags_q.c;
    assign flags[V_BIT] = flags_q.v;

endmodule
